alu_wb_collector: RTL and testbench

- Receiving end of the ALU result handshake: drives wb_ready to alu_fsm and captures each completed result (alu_out, write_en, ZNCV flags, warp_id_o) on done.
- Buffers results in a small FIFO and drains them to the register-file write port with a valid/ready handshake.
- Filters illegal-opcode and empty-mask results, reports exceptions and keeps retirement/error statistics.
- Sits between alu_fsm and the per-warp register file in the SIMD lane datapath.

---
 rtl/alu_wb_collector_if.sv | 47 ++++
 rtl/alu_wb_collector.sv | 140 ++++++++++++++
 tb/tb_alu_wb_collector.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_collector_if
// Description : ALU-result / register-file write-back bus seen by the collector.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_wb_collector_if #(
    parameter int CNT_W = 16
);
    // ALU side
    logic             done;
    logic [31:0]      alu_out;
    logic [3:0]       write_en;
    logic [3:0]       Z;
    logic [3:0]       N;
    logic [3:0]       C;
    logic [3:0]       V;
    logic             illegal_opcode;
    logic [4:0]       warp_id;
    logic             flush;
    logic             wb_ready;
    // register-file side
    logic             rf_valid;
    logic             rf_ready;
    logic [4:0]       rf_warp;
    logic [31:0]      rf_data;
    logic [3:0]       rf_byte_en;
    logic [15:0]      rf_flags;
    // status
    logic             exc_valid;
    logic [4:0]       exc_warp;
    logic [CNT_W-1:0] retire_cnt;
    logic             overflow_err;

    modport slave (
        input  done, alu_out, write_en, Z, N, C, V, illegal_opcode, warp_id, flush, rf_ready,
        output wb_ready, rf_valid, rf_warp, rf_data, rf_byte_en, rf_flags,
               exc_valid, exc_warp, retire_cnt, overflow_err
    );

    modport master (
        output done, alu_out, write_en, Z, N, C, V, illegal_opcode, warp_id, flush, rf_ready,
        input  wb_ready, rf_valid, rf_warp, rf_data, rf_byte_en, rf_flags,
               exc_valid, exc_warp, retire_cnt, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_wb_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_collector
// Description : Captures ALU results, filters illegal/empty ones and drains the
//               rest to the register file through a first-word-fall-through FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module alu_wb_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_wb_collector_if.slave bus
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [CNT_W-1:0]   c_RET_ONE = 1;

    typedef struct packed {
        logic [4:0]  warp;
        logic [31:0] data;
        logic [3:0]  byte_en;
        logic [15:0] flags;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_exc_valid;
    logic [4:0]         r_exc_warp;
    logic [CNT_W-1:0]   r_retire_cnt;
    logic               r_overflow_err;

    logic               w_wb_ready;
    logic               w_rf_valid;
    logic               w_accept;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    entry_t             w_new;
    entry_t             w_head;

    // Handshake readiness depends on registered occupancy only.
    assign w_wb_ready = (r_count != c_FULL);
    assign w_rf_valid = (r_count != '0);

    assign w_accept = bus.done & w_wb_ready;
    assign w_drop   = bus.done & ~w_wb_ready;
    assign w_push   = w_accept & ~bus.illegal_opcode & (bus.write_en != 4'b0000) & ~bus.flush;
    assign w_pop    = w_rf_valid & bus.rf_ready & ~bus.flush;

    always_comb begin
        w_new.warp    = bus.warp_id;
        w_new.data    = bus.alu_out;
        w_new.byte_en = bus.write_en;
        w_new.flags   = {bus.V, bus.C, bus.N, bus.Z};
    end

    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_valid    <= 1'b0;
            r_exc_warp     <= '0;
            r_retire_cnt   <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_exc_valid <= w_accept & bus.illegal_opcode;
            if (w_accept && bus.illegal_opcode) begin
                r_exc_warp <= bus.warp_id;
            end
            if (w_accept && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + c_RET_ONE;
            end
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so reset shows clean outputs.
    assign w_head = r_mem[r_rd_ptr];

    assign bus.wb_ready     = w_wb_ready;
    assign bus.rf_valid     = w_rf_valid;
    assign bus.rf_warp      = w_rf_valid ? w_head.warp    : '0;
    assign bus.rf_data      = w_rf_valid ? w_head.data    : '0;
    assign bus.rf_byte_en   = w_rf_valid ? w_head.byte_en : '0;
    assign bus.rf_flags     = w_rf_valid ? w_head.flags   : '0;
    assign bus.exc_valid    = r_exc_valid;
    assign bus.exc_warp     = r_exc_warp;
    assign bus.retire_cnt   = r_retire_cnt;
    assign bus.overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb_collector
// Description : Self-checking bench with directed scenarios and a queue model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_wb_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_wb_collector_if #(.CNT_W(CNT_W)) bus ();

    alu_wb_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  warp;
        logic [31:0] data;
        logic [3:0]  be;
        logic [15:0] flags;
    } ent_t;

    typedef struct packed {
        logic             wb_ready;
        logic             rf_valid;
        logic [4:0]       warp;
        logic [31:0]      data;
        logic [3:0]       be;
        logic [15:0]      flags;
        logic             exc_valid;
        logic [4:0]       exc_warp;
        logic [CNT_W-1:0] retire;
        logic             ovf;
    } out_t;

    ent_t        q[$];
    int unsigned m_retire;
    bit          m_ovf;
    bit          m_exc_valid;
    logic [4:0]  m_exc_warp;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic idle_inputs();
        bus.done = 1'b0; bus.alu_out = '0; bus.write_en = '0;
        bus.Z = '0; bus.N = '0; bus.C = '0; bus.V = '0;
        bus.illegal_opcode = 1'b0; bus.warp_id = '0; bus.flush = 1'b0;
    endtask

    task automatic set_res(input logic [31:0] d, input logic [3:0] we, input logic [4:0] w);
        bus.done = 1'b1; bus.alu_out = d; bus.write_en = we; bus.warp_id = w;
        bus.Z = d[3:0]; bus.N = d[7:4]; bus.C = d[11:8]; bus.V = d[15:12];
        bus.illegal_opcode = 1'b0;
    endtask

    task automatic model_reset();
        q.delete(); m_retire = 0; m_ovf = 0; m_exc_valid = 0; m_exc_warp = '0;
    endtask

    // Advances one clock while applying the write-back rules to the queue model.
    task automatic tick();
        bit   ready, accept, pop;
        ent_t e;
        ready  = (q.size() != DEPTH);
        accept = bus.done && ready;
        pop    = (q.size() != 0) && bus.rf_ready;
        m_exc_valid = accept && bus.illegal_opcode;
        if (m_exc_valid) m_exc_warp = bus.warp_id;
        if (bus.done && !ready) m_ovf = 1;
        if (accept && m_retire != (2**CNT_W - 1)) m_retire++;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (accept && !bus.illegal_opcode && bus.write_en != 4'b0) begin
                e.warp = bus.warp_id; e.data = bus.alu_out; e.be = bus.write_en;
                e.flags = {bus.V, bus.C, bus.N, bus.Z};
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic out_t model_out();
        out_t o;
        o = '0;
        o.wb_ready = (q.size() != DEPTH);
        o.rf_valid = (q.size() != 0);
        if (q.size() != 0) begin
            o.warp = q[0].warp; o.data = q[0].data; o.be = q[0].be; o.flags = q[0].flags;
        end
        o.exc_valid = m_exc_valid; o.exc_warp = m_exc_warp;
        o.retire = CNT_W'(m_retire); o.ovf = m_ovf;
        return o;
    endfunction

    function automatic out_t dut_out();
        return '{bus.wb_ready, bus.rf_valid, bus.rf_warp, bus.rf_data, bus.rf_byte_en,
                 bus.rf_flags, bus.exc_valid, bus.exc_warp, bus.retire_cnt, bus.overflow_err};
    endfunction

    task automatic test_reset();
        out_t o;
        idle_inputs(); bus.rf_ready = 1'b0; rst_n = 1'b0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        o = dut_out();
        n_checks++;
        if (o !== out_t'({1'b1, 81'b0})) $display("FAIL reset_outputs: got %h want %h", o, out_t'({1'b1, 81'b0}));
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus.rf_ready = 1'b1;
        set_res(32'h04030201, 4'b1111, 5'd7); bus.Z = 4'b0000;
        tick(); idle_inputs();
        n_checks++;
        if ({bus.rf_valid, bus.rf_data, bus.rf_byte_en, bus.rf_warp} !== {1'b1, 32'h04030201, 4'hF, 5'd7})
            $display("FAIL single_head: got v=%b d=%h be=%h w=%0d want v=1 d=04030201 be=f w=7",
                     bus.rf_valid, bus.rf_data, bus.rf_byte_en, bus.rf_warp);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.rf_valid, bus.retire_cnt} !== {1'b0, 16'd1})
            $display("FAIL single_pop: got v=%b retire=%0d want v=0 retire=1", bus.rf_valid, bus.retire_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
        bus.rf_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_res(exp_d[k], 4'hF, 5'(k + 1)); tick();
        end
        idle_inputs();
        n_checks++;
        if (bus.wb_ready !== 1'b0) $display("FAIL bp_full: wb_ready got %b want 0", bus.wb_ready);
        else n_pass++;
        bus.rf_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus.rf_valid, bus.rf_data} !== {1'b1, exp_d[k]})
                $display("FAIL bp_order%0d: got v=%b d=%h want v=1 d=%h", k, bus.rf_valid, bus.rf_data, exp_d[k]);
            else n_pass++;
            tick();
            if (k == 0) begin
                n_checks++;
                if (bus.wb_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", bus.wb_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.rf_valid !== 1'b0) $display("FAIL bp_empty: rf_valid got %b want 0", bus.rf_valid);
        else n_pass++;
    endtask

    task automatic test_masked_illegal();
        int unsigned r0;
        r0 = m_retire;
        bus.rf_ready = 1'b1;
        set_res(32'hCAFEF00D, 4'b0000, 5'd3); tick(); idle_inputs();
        n_checks++;
        if ({bus.rf_valid, bus.retire_cnt} !== {1'b0, CNT_W'(r0 + 1)})
            $display("FAIL masked: got v=%b retire=%0d want v=0 retire=%0d", bus.rf_valid, bus.retire_cnt, r0 + 1);
        else n_pass++;
        set_res(32'h12345678, 4'hF, 5'd9); bus.illegal_opcode = 1'b1; tick(); idle_inputs();
        n_checks++;
        if ({bus.exc_valid, bus.exc_warp, bus.rf_valid} !== {1'b1, 5'd9, 1'b0})
            $display("FAIL illegal_pulse: got exc=%b warp=%0d v=%b want exc=1 warp=9 v=0",
                     bus.exc_valid, bus.exc_warp, bus.rf_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.exc_valid, bus.exc_warp, bus.retire_cnt} !== {1'b0, 5'd9, CNT_W'(r0 + 2)})
            $display("FAIL illegal_after: got exc=%b warp=%0d retire=%0d want exc=0 warp=9 retire=%0d",
                     bus.exc_valid, bus.exc_warp, bus.retire_cnt, r0 + 2);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [CNT_W-1:0] r0;
        bus.rf_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_res(32'hA0A0A0A0 + 32'(k), 4'hF, 5'(20 + k)); tick();
        end
        r0 = bus.retire_cnt;
        set_res(32'hDEADBEEF, 4'hF, 5'd31);
        tick(); tick(); idle_inputs();
        n_checks++;
        if ({bus.overflow_err, bus.retire_cnt} !== {1'b1, r0})
            $display("FAIL ovf_set: got ovf=%b retire=%0d want ovf=1 retire=%0d", bus.overflow_err, bus.retire_cnt, r0);
        else n_pass++;
        bus.rf_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus.rf_valid, bus.rf_data} !== {1'b1, 32'hA0A0A0A0 + 32'(k)})
                $display("FAIL ovf_contents%0d: got v=%b d=%h want v=1 d=%h", k, bus.rf_valid, bus.rf_data,
                         32'hA0A0A0A0 + 32'(k));
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bus.overflow_err, bus.rf_valid} !== {1'b1, 1'b0})
            $display("FAIL ovf_sticky: got ovf=%b v=%b want ovf=1 v=0", bus.overflow_err, bus.rf_valid);
        else n_pass++;
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] d [5];
        for (int k = 0; k < 5; k++) d[k] = 32'h50000000 + 32'(k * 32'h01010101);
        bus.rf_ready = 1'b0;
        set_res(d[0], 4'hF, 5'd1); tick();
        set_res(d[1], 4'hF, 5'd2); tick();
        bus.rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({bus.wb_ready, bus.rf_data} !== {1'b1, d[k]})
                $display("FAIL pp_head%0d: got rdy=%b d=%h want rdy=1 d=%h", k, bus.wb_ready, bus.rf_data, d[k]);
            else n_pass++;
            set_res(d[k + 2], 4'hF, 5'(k + 3)); tick();
        end
        idle_inputs();
        for (int k = 3; k < 5; k++) begin
            n_checks++;
            if ({bus.rf_valid, bus.rf_data} !== {1'b1, d[k]})
                $display("FAIL pp_drain%0d: got v=%b d=%h want v=1 d=%h", k, bus.rf_valid, bus.rf_data, d[k]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (bus.rf_valid !== 1'b0) $display("FAIL pp_count: rf_valid got %b want 0", bus.rf_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] r0;
        bus.rf_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_res(32'h77000000 + 32'(k), 4'hF, 5'd4); tick();
        end
        r0 = bus.retire_cnt;
        set_res(32'h88888888, 4'hF, 5'd5); bus.flush = 1'b1; tick(); idle_inputs();
        n_checks++;
        if ({bus.rf_valid, bus.wb_ready, bus.retire_cnt} !== {1'b0, 1'b1, r0 + CNT_W'(1)})
            $display("FAIL flush: got v=%b rdy=%b retire=%0d want v=0 rdy=1 retire=%0d",
                     bus.rf_valid, bus.wb_ready, bus.retire_cnt, r0 + CNT_W'(1));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        out_t o;
        bus.rf_ready = 1'b0;
        set_res(32'h01020304, 4'hF, 5'd6); tick();
        set_res(32'h05060708, 4'hF, 5'd6); tick();
        bus.rf_ready = 1'b1;
        set_res(32'h090A0B0C, 4'hF, 5'd6); tick();
        bus.rf_ready = 1'b0; idle_inputs(); tick();
        bus.rf_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        o = dut_out();
        n_checks++;
        if (o !== out_t'({1'b1, 81'b0})) $display("FAIL async_reset: got %h want %h", o, out_t'({1'b1, 81'b0}));
        else n_pass++;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.wb_ready, bus.rf_valid} !== 2'b10)
            $display("FAIL async_release: got rdy=%b v=%b want rdy=1 v=0", bus.wb_ready, bus.rf_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        out_t o, e;
        int   errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            bus.done = (q.size() == DEPTH) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            bus.alu_out = $urandom;
            bus.write_en = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            bus.Z = 4'($urandom); bus.N = 4'($urandom); bus.C = 4'($urandom); bus.V = 4'($urandom);
            bus.illegal_opcode = ($urandom_range(0, 7) == 0);
            bus.warp_id = 5'($urandom);
            bus.flush = ($urandom_range(0, 31) == 0);
            bus.rf_ready = ($urandom_range(0, 2) != 0);
            tick();
            o = dut_out(); e = model_out();
            n_checks++;
            if (o !== e) begin
                if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", i, o, e);
                errs++;
            end else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        model_reset();
        test_single();
        test_backpressure();
        test_masked_illegal();
        test_overflow();
        test_simul_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
